// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state type and request legality check for the LSU.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAPTURE,
    ST_WR_ISSUE,
    ST_RESP
  } lsu_state_e;

  // High when the width code is not legal for the direction or the address is misaligned for it.
  function automatic logic lsu_bad_access(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = offset[0];
      F3_W:    bad = |offset;
      F3_BU:   bad = we;
      F3_HU:   bad = we | offset[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational lane select/extension of a memory word, plus the byte-lane mask of the access
// (the mask drives the read-modify-write merge for sub-word stores).
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic [31:0] lane_mask_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = word_i[{offset_i, 3'b000} +: 8];
    half_sel    = word_i[{offset_i[1], 4'b0000} +: 16];
    rdata_o     = '0;
    lane_mask_o = '1;
    case (funct3_i)
      F3_B: begin
        rdata_o     = {{24{byte_sel[7]}}, byte_sel};
        lane_mask_o = 32'h0000_00FF << {offset_i, 3'b000};
      end
      F3_BU: begin
        rdata_o     = {24'h0, byte_sel};
        lane_mask_o = 32'h0000_00FF << {offset_i, 3'b000};
      end
      F3_H: begin
        rdata_o     = {{16{half_sel[15]}}, half_sel};
        lane_mask_o = 32'h0000_FFFF << {offset_i[1], 4'b0000};
      end
      F3_HU: begin
        rdata_o     = {16'h0, half_sel};
        lane_mask_o = 32'h0000_FFFF << {offset_i[1], 4'b0000};
      end
      F3_W:    rdata_o = word_i;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit: one request at a time onto a word-addressed memory; loads 3 cycles, SW 2,
// SB/SH 4 (read-modify-write), errors 1. req_ready is low while a request is in flight.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16384
) (
  input  logic        lsu_clk,
  input  logic        lsu_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write_en,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read_en,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        mem_write_en_q, mem_write_en_d;
  logic [31:0] mem_write_addr_q, mem_write_addr_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        mem_read_en_q, mem_read_en_d;
  logic [31:0] mem_read_addr_q, mem_read_addr_d;

  logic        accept;
  logic        req_bad;
  logic [31:0] load_data;
  logic [31:0] lane_mask;
  logic [31:0] merged_word;

  assign accept  = req_valid && req_ready_q;
  assign req_bad = lsu_bad_access(req_we, req_funct3, req_addr[1:0])
                || ({2'b00, req_addr[31:2]} >= MEM_WORDS);

  lsu_load_align u_align (
    .word_i      (mem_read_data),
    .offset_i    (addr_q[1:0]),
    .funct3_i    (funct3_q),
    .rdata_o     (load_data),
    .lane_mask_o (lane_mask)
  );

  // Store data is LSB-aligned; shift it into its lane before masking into the captured word.
  assign merged_word = (mem_read_data & ~lane_mask)
                     | ((wdata_q << {addr_q[1:0], 3'b000}) & lane_mask);

  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    funct3_d         = funct3_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    req_ready_d      = 1'b0;
    rsp_valid_d      = 1'b0;
    rsp_err_d        = 1'b0;
    rsp_rdata_d      = '0;
    mem_write_en_d   = 1'b0;
    mem_write_addr_d = '0;
    mem_write_data_d = '0;
    mem_read_en_d    = 1'b0;
    mem_read_addr_d  = '0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (!req_we || req_funct3 != F3_W) begin
            mem_read_en_d   = 1'b1;
            mem_read_addr_d = {2'b00, req_addr[31:2]};
            state_d         = ST_RD_ISSUE;
          end else begin
            mem_write_en_d   = 1'b1;
            mem_write_addr_d = {2'b00, req_addr[31:2]};
            mem_write_data_d = req_wdata;
            state_d          = ST_WR_ISSUE;
          end
        end else begin
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAPTURE;
      ST_RD_CAPTURE: begin
        if (we_q) begin
          mem_write_en_d   = 1'b1;
          mem_write_addr_d = {2'b00, addr_q[31:2]};
          mem_write_data_d = merged_word;
          state_d          = ST_WR_ISSUE;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          req_ready_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_WR_ISSUE: begin
        rsp_valid_d = 1'b1;
        req_ready_d = 1'b1;
        state_d     = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge lsu_clk) begin
    if (!lsu_rst_n) begin
      state_q          <= ST_IDLE;
      we_q             <= 1'b0;
      funct3_q         <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      req_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_err_q        <= 1'b0;
      rsp_rdata_q      <= '0;
      mem_write_en_q   <= 1'b0;
      mem_write_addr_q <= '0;
      mem_write_data_q <= '0;
      mem_read_en_q    <= 1'b0;
      mem_read_addr_q  <= '0;
    end else begin
      state_q          <= state_d;
      we_q             <= we_d;
      funct3_q         <= funct3_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      req_ready_q      <= req_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_err_q        <= rsp_err_d;
      rsp_rdata_q      <= rsp_rdata_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_write_addr_q <= mem_write_addr_d;
      mem_write_data_q <= mem_write_data_d;
      mem_read_en_q    <= mem_read_en_d;
      mem_read_addr_q  <= mem_read_addr_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_write_addr = mem_write_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read_en    = mem_read_en_q;
  assign mem_read_addr  = mem_read_addr_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: transaction-level model predicts every output per cycle,
// plus directed literal checks of the documented scenarios.
module tb_lsu_mem_initiator;

  logic        lsu_clk = 1'b0;
  logic        lsu_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_write_en;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic        mem_read_en;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;

  lsu_mem_initiator dut (
    .lsu_clk        (lsu_clk),
    .lsu_rst_n      (lsu_rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_read_en    (mem_read_en),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data)
  );

  always #5 lsu_clk = ~lsu_clk;

  int total = 0;
  int bad   = 0;

  // Data memory seen by the DUT: one-cycle registered read, write on enable.
  logic [31:0] mem [16384];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = i * 32'h9E37_79B1;
    mem[16'h10] = 32'h8081_7F22;
    mem_read_data = '0;
    forever begin
      @(posedge lsu_clk);
      if (mem_read_en)  mem_read_data <= mem[mem_read_addr[13:0]];
      if (mem_write_en) mem[mem_write_addr[13:0]] <= mem_write_data;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16384];
  logic        e_ready [1024];
  logic        e_rv    [1024];
  logic        e_err   [1024];
  logic [31:0] e_rdata [1024];
  logic        e_ren   [1024];
  logic [31:0] e_raddr [1024];
  logic        e_wen   [1024];
  logic [31:0] e_waddr [1024];
  logic [31:0] e_wdata [1024];

  int          ec = 0;
  bit          started = 0;
  int          busy_until = 0;
  bit          pend = 0;
  int          pend_e, pend_a;
  logic [31:0] pend_d;

  function automatic int sl(input int x);
    return x & 1023;
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    logic legal;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 32'd1 << (int'(f3) % 4);
    return !legal || (a % size != 0) || ((a / 4) >= 16384);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input logic [2:0] f3);
    int unsigned v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (w >> (8 * off)) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input int off,
                                              input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    r  = w;
    nb = (f3 == 3'd0) ? 1 : 2;
    for (int i = 0; i < nb; i++) r[8 * (off + i) +: 8] = wd[8 * i +: 8];
    return r;
  endfunction

  task automatic clr(input int k);
    e_ready[k] = 0; e_rv[k] = 0; e_err[k] = 0; e_rdata[k] = 0;
    e_ren[k] = 0; e_raddr[k] = 0; e_wen[k] = 0; e_waddr[k] = 0; e_wdata[k] = 0;
  endtask

  initial begin
    int L, widx, off, k;
    for (int i = 0; i < 16384; i++) ref_mem[i] = i * 32'h9E37_79B1;
    ref_mem[16'h10] = 32'h8081_7F22;
    forever begin
      @(posedge lsu_clk);
      ec = ec + 1;
      k  = sl(ec);
      if (!lsu_rst_n) begin
        started    = 1;
        pend       = 0;
        busy_until = ec;
        clr(k);
      end else if (started) begin
        if (pend && pend_e == ec) begin
          ref_mem[pend_a] = pend_d;
          pend = 0;
        end
        if (req_valid && e_ready[sl(ec - 1)]) begin
          widx = int'(req_addr >> 2);
          off  = int'(req_addr & 32'd3);
          for (int j = 0; j < 4; j++) clr(sl(ec + j));
          if (model_err(req_we, req_funct3, req_addr)) begin
            L = 1;
            e_err[k] = 1;
          end else if (!req_we) begin
            L = 3;
            e_ren[k] = 1; e_raddr[k] = widx;
            e_rdata[sl(ec + 2)] = model_load(ref_mem[widx], off, req_funct3);
          end else if (req_funct3 == 3'd2) begin
            L = 2;
            e_wen[k] = 1; e_waddr[k] = widx; e_wdata[k] = req_wdata;
            ref_mem[widx] = req_wdata;
          end else begin
            L = 4;
            e_ren[k] = 1; e_raddr[k] = widx;
            pend   = 1;
            pend_e = ec + 2;
            pend_a = widx;
            pend_d = model_merge(ref_mem[widx], off, req_funct3, req_wdata);
            e_wen[sl(ec + 2)] = 1; e_waddr[sl(ec + 2)] = widx; e_wdata[sl(ec + 2)] = pend_d;
          end
          e_rv[sl(ec + L - 1)]    = 1;
          e_ready[sl(ec + L - 1)] = 1;
          busy_until = ec + L - 1;
        end else if (ec > busy_until) begin
          clr(k);
          e_ready[k] = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int   rd2_cnt = 0;
  logic prev_ren = 0;
  initial begin
    int k;
    forever begin
      @(negedge lsu_clk);
      if (started) begin
        k = sl(ec);
        total++;
        if (req_ready !== e_ready[k] || rsp_valid !== e_rv[k] || rsp_err !== e_err[k] ||
            rsp_rdata !== e_rdata[k] || mem_read_en !== e_ren[k] || mem_read_addr !== e_raddr[k] ||
            mem_write_en !== e_wen[k] || mem_write_addr !== e_waddr[k] || mem_write_data !== e_wdata[k]) begin
          bad++;
          $display("FAIL cycle %0d: got rdy=%b rv=%b err=%b rd=%h ren=%b ra=%h wen=%b wa=%h wd=%h want rdy=%b rv=%b err=%b rd=%h ren=%b ra=%h wen=%b wa=%h wd=%h",
                   ec, req_ready, rsp_valid, rsp_err, rsp_rdata, mem_read_en, mem_read_addr,
                   mem_write_en, mem_write_addr, mem_write_data, e_ready[k], e_rv[k], e_err[k],
                   e_rdata[k], e_ren[k], e_raddr[k], e_wen[k], e_waddr[k], e_wdata[k]);
        end
        if (mem_read_en && prev_ren) rd2_cnt++;
        prev_ren = mem_read_en;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int acc);
    bit done;
    done = 0;
    acc  = -1;
    @(negedge lsu_clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 30 && !done; i++) begin
      if (req_ready === 1'b1) begin
        @(posedge lsu_clk);
        #1;
        acc  = ec;
        done = 1;
      end else begin
        @(negedge lsu_clk);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept, want accept within 30 cycles");
      req_valid = 1'b0;
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic [31:0] er, output int rf, output int wf,
                         output logic [31:0] ra, output logic [31:0] wa, output logic [31:0] wdv);
    int acc;
    lat = 0; rd = 0; er = 0; rf = 0; wf = 0; ra = 0; wa = 0; wdv = 0;
    issue(we, f3, a, wd, acc);
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge lsu_clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_read_en && rf == 0) begin rf = k; ra = mem_read_addr; end
      if (mem_write_en && wf == 0) begin wf = k; wa = mem_write_addr; wdv = mem_write_data; end
      if (rsp_valid) begin lat = k; rd = rsp_rdata; er = {31'b0, rsp_err}; end
    end
  endtask

  int          lat, rf, wf, e1, e2, acc;
  logic [31:0] rd, er, ra, wa, wdv;
  logic [2:0]  sub_f3  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
  logic [31:0] sub_a   [4] = '{32'h43, 32'h43, 32'h42, 32'h40};
  logic [31:0] sub_exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_7F22};
  logic        err_we  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0]  err_f3  [4] = '{3'd1, 3'd2, 3'd3, 3'd2};
  logic [31:0] err_a   [4] = '{32'h41, 32'h42, 32'h40, 32'h0001_0000};

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish, want finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       rwe;
    logic [2:0] rf3;
    logic [31:0] raddr;
    lsu_rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge lsu_clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_outputs", {29'b0, rsp_valid, mem_read_en, mem_write_en}, 32'd0);
    lsu_rst_n = 1'b1;
    @(negedge lsu_clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    run_req(1'b0, 3'd2, 32'h40, 32'h0, lat, rd, er, rf, wf, ra, wa, wdv);
    chk("lw_lat", lat, 32'd3);
    chk("lw_rdata", rd, 32'h8081_7F22);
    chk("lw_err", er, 32'd0);
    chk("lw_rd_cycle", rf, 32'd1);
    chk("lw_rd_addr", ra, 32'h10);

    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, sub_f3[i], sub_a[i], 32'h0, lat, rd, er, rf, wf, ra, wa, wdv);
      chk($sformatf("subload%0d_rdata", i), rd, sub_exp[i]);
      chk($sformatf("subload%0d_lat", i), lat, 32'd3);
    end

    run_req(1'b1, 3'd0, 32'h41, 32'h0000_00AB, lat, rd, er, rf, wf, ra, wa, wdv);
    chk("sb_lat", lat, 32'd4);
    chk("sb_rd_cycle", rf, 32'd1);
    chk("sb_wr_cycle", wf, 32'd3);
    chk("sb_wr_addr", wa, 32'h10);
    chk("sb_wr_data", wdv, 32'h8081_AB22);
    chk("sb_rdata", rd, 32'd0);
    run_req(1'b0, 3'd2, 32'h40, 32'h0, lat, rd, er, rf, wf, ra, wa, wdv);
    chk("lw_after_sb", rd, 32'h8081_AB22);

    for (int i = 0; i < 4; i++) begin
      run_req(err_we[i], err_f3[i], err_a[i], 32'hDEAD_BEEF, lat, rd, er, rf, wf, ra, wa, wdv);
      chk($sformatf("err%0d_lat", i), lat, 32'd1);
      chk($sformatf("err%0d_flag", i), er, 32'd1);
      chk($sformatf("err%0d_rdata", i), rd, 32'd0);
      chk($sformatf("err%0d_mem_en", i), rf + wf, 32'd0);
    end

    issue(1'b0, 3'd2, 32'h40, 32'h0, e1);
    issue(1'b0, 3'd2, 32'h44, 32'h0, e2);
    @(negedge lsu_clk);
    req_valid = 1'b0;
    chk("b2b_accept_gap", e2 - e1, 32'd3);
    repeat (4) @(negedge lsu_clk);

    issue(1'b1, 3'd1, 32'h40, 32'h0000_5555, acc);
    @(negedge lsu_clk);
    req_valid = 1'b0;
    @(negedge lsu_clk);
    lsu_rst_n = 1'b0;
    @(negedge lsu_clk);
    chk("rstmid_outputs", {28'b0, req_ready, rsp_valid, mem_read_en, mem_write_en}, 32'd0);
    lsu_rst_n = 1'b1;
    @(negedge lsu_clk);
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) @(negedge lsu_clk);
    chk("rstmid_mem_kept", mem[16'h10], 32'h8081_AB22);

    for (int n = 0; n < 250; n++) begin
      rwe   = 1'($urandom_range(0, 1));
      rf3   = (rwe && $urandom_range(0, 7) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      raddr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
      issue(rwe, rf3, raddr, $urandom, acc);
      if ($urandom_range(0, 19) == 0) begin
        @(negedge lsu_clk);
        req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge lsu_clk);
        lsu_rst_n = 1'b0;
        @(negedge lsu_clk);
        lsu_rst_n = 1'b1;
      end else if ($urandom_range(0, 2) == 0) begin
        @(negedge lsu_clk);
        req_valid = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge lsu_clk);
      end
    end
    @(negedge lsu_clk);
    req_valid = 1'b0;
    repeat (8) @(negedge lsu_clk);
    chk("rd_en_consecutive", rd2_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
